// File: rtl/bin_ker_pkg.sv
// Shared types and width helpers for the binary-kernel accumulator.
// Optional XNOR mode is enabled with BIN_CONV_XNOR_EN.
package bin_ker_pkg;

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  localparam logic MODE_AND  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bin_popcount.sv
// Combinational population count of a W-bit vector.
// Used on the per-row kernel/image product.
module bin_popcount #(
  parameter int W = 3
) (
  input  logic [W-1:0]           v,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(v[i]);
    end
  end

endmodule

// File: rtl/bin_conv_acc.sv
// Streaming KxK binary-kernel accumulator, one image row per handshake.
// Define BIN_CONV_XNOR_EN to add the mode port (AND / XNOR product).
module bin_conv_acc
  import bin_ker_pkg::*;
#(
  parameter int K     = 3,
  parameter int OUT_W = cnt_w(K * K)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 k_wr,
  input  logic [$clog2(K)-1:0] k_addr,
  input  logic [K-1:0]         k_data,
  output logic                 k_err,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         im_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     result
`ifdef BIN_CONV_XNOR_EN
  ,
  input  logic                 mode
`endif
);

  localparam int AW = $clog2(K);
  localparam int CW = cnt_w(K);

  state_t              state;
  logic [AW-1:0]       row_cnt;
  logic [OUT_W-1:0]    acc;
  logic [K-1:0]        kern [K];
  logic [K-1:0]        krow;
  logic [K-1:0]        prod;
  logic [CW-1:0]       cnt;
  logic [OUT_W-1:0]    sum;
  logic                mode_x;
  logic                wr_ok;
  logic                last;

`ifdef BIN_CONV_XNOR_EN
  assign mode_x = mode;
`else
  assign mode_x = MODE_AND;
`endif

  assign krow = kern[row_cnt];
  assign prod = (mode_x == MODE_XNOR) ? ~(im_row ^ krow)
                                      : (im_row & krow);

  bin_popcount #(.W(K)) u_pop (
    .v   (prod),
    .cnt (cnt)
  );

  assign sum  = acc + OUT_W'(cnt);
  assign last = (row_cnt == AW'(K - 1));

  // Kernel may only change between windows so a window sees one kernel.
  assign wr_ok = (state == ACC) && (row_cnt == '0) &&
                 ({1'b0, k_addr} < (AW + 1)'(K));

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      row_cnt <= '0;
      acc     <= '0;
      result  <= '0;
      k_err   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        kern[i] <= '0;
      end
    end else begin
      k_err <= 1'b0;
      if (k_wr) begin
        if (wr_ok) kern[k_addr] <= k_data;
        else       k_err <= 1'b1;
      end
      if (clr) begin
        state   <= ACC;
        row_cnt <= '0;
        acc     <= '0;
      end else begin
        unique case (state)
          ACC: begin
            if (in_valid) begin
              if (last) begin
                result  <= sum;
                acc     <= '0;
                row_cnt <= '0;
                state   <= HOLD;
              end else begin
                acc     <= sum;
                row_cnt <= row_cnt + AW'(1);
              end
            end
          end
          HOLD: begin
            if (out_ready) state <= ACC;
          end
          default: state <= ACC;
        endcase
      end
    end
  end

endmodule
